vga_write_arbiter: RTL and testbench

- Owns the single write port of the video RAM (16x12 cells, 3-bit RGB).
- Shares that port between two requesters:
  - CPU-side VGA instruction writes.
  - An internal rectangle-fill engine, so whole regions can be painted without a per-pixel software loop.
- Sits between the CPU datapath and the video RAM write inputs (write enable, write address, write data).

---
 rtl/vga_write_arbiter_if.sv | 38 +++
 rtl/vga_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_vga_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_write_arbiter_if.sv
// Bundle of CPU write, fill-engine control and video RAM write signals for the arbiter.
interface vga_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 8
);
  // CPU write requester
  logic                  iCpuReq;
  logic [ADDR_WIDTH-1:0] iCpuAddr;
  logic [DATA_WIDTH-1:0] iCpuData;
  logic                  oCpuStall;

  // Rectangle fill control
  logic                  iFillStart;
  logic [3:0]            iFillX;
  logic [3:0]            iFillY;
  logic [4:0]            iFillW;
  logic [4:0]            iFillH;
  logic [DATA_WIDTH-1:0] iFillColor;
  logic                  oFillBusy;
  logic                  oFillDone;

  // Video RAM write port
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [DATA_WIDTH-1:0] oWriteData;

  // Requester side: CPU datapath and fill command source
  modport master (
    output iCpuReq, iCpuAddr, iCpuData, iFillStart, iFillX, iFillY, iFillW, iFillH, iFillColor,
    input  oCpuStall, oFillBusy, oFillDone, oWriteEnable, oWriteAddress, oWriteData
  );

  // Arbiter side
  modport slave (
    input  iCpuReq, iCpuAddr, iCpuData, iFillStart, iFillX, iFillY, iFillW, iFillH, iFillColor,
    output oCpuStall, oFillBusy, oFillDone, oWriteEnable, oWriteAddress, oWriteData
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Video RAM write-port owner: alternates between CPU writes and a clipped rectangle-fill engine.
module vga_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_WIDTH  = 16,
  parameter int unsigned MEM_HEIGHT = 12
) (
  input logic          Clock,
  input logic          Reset,
  vga_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} stateT;

  localparam logic [5:0] MemW = 6'(MEM_WIDTH);
  localparam logic [5:0] MemH = 6'(MEM_HEIGHT);

  stateT                 rState, nState;
  logic [4:0]            rX, rCx, rCy, rRight, rBottom;
  logic [DATA_WIDTH-1:0] rColor;
  logic                  rLastGrant;  // 1 = fill engine won the last granted cycle
  logic                  rBusy, rDone, nBusy, nDone;
  logic                  rWe;
  logic [ADDR_WIDTH-1:0] rAddr;
  logic [DATA_WIDTH-1:0] rData;

  logic                  fillReq, cpuGrant, fillGrant, lastCell, regionEmpty;
  logic [5:0]            sumX, sumY, clipX, clipY;
  logic [4:0]            startRight, startBottom;
  logic [ADDR_WIDTH-1:0] fillAddr;

  // Clip the requested rectangle to the memory at 6 bits so X+W / Y+H never overflow
  always_comb begin
    sumX        = {2'b00, bus.iFillX} + {1'b0, bus.iFillW};
    sumY        = {2'b00, bus.iFillY} + {1'b0, bus.iFillH};
    clipX       = (sumX > MemW) ? MemW : sumX;
    clipY       = (sumY > MemH) ? MemH : sumY;
    startRight  = 5'(clipX - 6'd1);
    startBottom = 5'(clipY - 6'd1);
    regionEmpty = (bus.iFillW == 5'd0) || (bus.iFillH == 5'd0) ||
                  ({2'b00, bus.iFillX} >= MemW) || ({2'b00, bus.iFillY} >= MemH);
  end

  assign lastCell = (rCx == rRight) && (rCy == rBottom);
  assign fillAddr = ADDR_WIDTH'(32'(rCy) * MEM_WIDTH + 32'(rCx));

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rState <= StIdle;
    end else begin
      rState <= nState;
    end
  end

  // Next-state logic; a start pulse outside idle is ignored
  always_comb begin
    nState = rState;
    unique case (rState)
      StIdle: begin
        if (bus.iFillStart) begin
          nState = regionEmpty ? StDone : StFill;
        end
      end
      StFill: begin
        if (fillGrant && lastCell) begin
          nState = StDone;
        end
      end
      StDone:  nState = StIdle;
      default: nState = StIdle;
    endcase
  end

  // Arbitration and FSM-derived outputs; on conflict the requester not granted last time wins
  always_comb begin
    fillReq       = (rState == StFill);
    cpuGrant      = bus.iCpuReq & (~fillReq | rLastGrant);
    fillGrant     = fillReq & (~bus.iCpuReq | ~rLastGrant);
    bus.oCpuStall = bus.iCpuReq & ~cpuGrant;
    nBusy         = (nState != StIdle);
    nDone         = (nState == StDone);
  end

  // Fill parameters latch at start; raster counters advance only on granted fill cycles
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rX      <= '0;
      rCx     <= '0;
      rCy     <= '0;
      rRight  <= '0;
      rBottom <= '0;
      rColor  <= '0;
    end else if ((rState == StIdle) && bus.iFillStart) begin
      rX      <= {1'b0, bus.iFillX};
      rCx     <= {1'b0, bus.iFillX};
      rCy     <= {1'b0, bus.iFillY};
      rRight  <= startRight;
      rBottom <= startBottom;
      rColor  <= bus.iFillColor;
    end else if (fillGrant) begin
      if (rCx == rRight) begin
        rCx <= rX;
        rCy <= rCy + 5'd1;
      end else begin
        rCx <= rCx + 5'd1;
      end
    end
  end

  // Registered RAM write port and status; address/data hold when nothing is granted
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rLastGrant <= 1'b1;
      rWe        <= 1'b0;
      rAddr      <= '0;
      rData      <= '0;
      rBusy      <= 1'b0;
      rDone      <= 1'b0;
    end else begin
      rBusy <= nBusy;
      rDone <= nDone;
      rWe   <= cpuGrant | fillGrant;
      if (cpuGrant) begin
        rLastGrant <= 1'b0;
        rAddr      <= bus.iCpuAddr;
        rData      <= bus.iCpuData;
      end else if (fillGrant) begin
        rLastGrant <= 1'b1;
        rAddr      <= fillAddr;
        rData      <= rColor;
      end
    end
  end

  assign bus.oWriteEnable  = rWe;
  assign bus.oWriteAddress = rAddr;
  assign bus.oWriteData    = rData;
  assign bus.oFillBusy     = rBusy;
  assign bus.oFillDone     = rDone;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: queue-based reference model plus directed tests.
module tb_vga_write_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  vga_write_arbiter_if #(.DATA_WIDTH(3), .ADDR_WIDTH(8)) bus ();

  vga_write_arbiter #(
    .DATA_WIDTH(3),
    .ADDR_WIDTH(8),
    .MEM_WIDTH (16),
    .MEM_HEIGHT(12)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial forever #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending fill cells as a queue of addresses
  int         mPhase = 0;  // 0 idle, 1 filling, 2 done
  int         mCells[$];
  bit         mLast  = 1'b1;  // 1 = fill granted last
  logic [2:0] mColor = '0;
  logic       eWe    = 1'b0;
  logic [7:0] eAddr  = '0;
  logic [2:0] eData  = '0;
  logic       eBusy  = 1'b0;
  logic       eDone  = 1'b0;

  // Observation log and counters, written only by the compare process
  int wAddr[$];
  int wData[$];
  int cyc         = 0;
  int busyCount   = 0;
  int doneCount   = 0;
  int lastWeCyc   = -1;
  int lastDoneCyc = -2;
  bit expStall;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chkEntry(input string name, input int idx, input int addr, input int data);
    if (idx < wAddr.size()) begin
      chk({name, "_addr"}, wAddr[idx], addr);
      chk({name, "_data"}, wData[idx], data);
    end else begin
      chk({name, "_present"}, 0, 1);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic startFill(input int x, input int y, input int w, input int h, input int col);
    bus.iFillX     = 4'(x);
    bus.iFillY     = 4'(y);
    bus.iFillW     = 5'(w);
    bus.iFillH     = 5'(h);
    bus.iFillColor = 3'(col);
    bus.iFillStart = 1'b1;
    tick();
    bus.iFillStart = 1'b0;
  endtask

  // Model update on each edge, computed from the rules on raster order and alternation
  initial forever begin
    @(posedge Clock or negedge Reset);
    if (!Reset) begin
      mPhase = 0;
      mCells.delete();
      mLast  = 1'b1;
      eWe    = 1'b0;
      eAddr  = '0;
      eData  = '0;
      eBusy  = 1'b0;
      eDone  = 1'b0;
    end else begin
      bit fr, cg, fg;
      fr  = (mPhase == 1);
      cg  = bus.iCpuReq && (!fr || mLast);
      fg  = fr && !cg;
      eWe = cg || fg;
      if (cg) begin
        eAddr = bus.iCpuAddr;
        eData = bus.iCpuData;
        mLast = 1'b0;
      end else if (fg) begin
        eAddr = 8'(mCells.pop_front());
        eData = mColor;
        mLast = 1'b1;
      end
      if (mPhase == 2) begin
        mPhase = 0;
      end else if (mPhase == 1) begin
        if (fg && mCells.size() == 0) mPhase = 2;
      end else if (bus.iFillStart) begin
        mCells.delete();
        mColor = bus.iFillColor;
        for (int r = int'(bus.iFillY); r < int'(bus.iFillY) + int'(bus.iFillH); r++) begin
          for (int c = int'(bus.iFillX); c < int'(bus.iFillX) + int'(bus.iFillW); c++) begin
            if (c < 16 && r < 12) mCells.push_back(r * 16 + c);
          end
        end
        mPhase = (mCells.size() == 0) ? 2 : 1;
      end
      eBusy = (mPhase != 0);
      eDone = (mPhase == 2);
    end
  end

  // Per-cycle compare against the model, mid-cycle, plus observation logging
  initial forever begin
    @(negedge Clock);
    if (Reset) begin
      cyc++;
      expStall = bus.iCpuReq && (mPhase == 1) && !mLast;
      checks++;
      if (bus.oWriteEnable !== eWe || bus.oWriteAddress !== eAddr || bus.oWriteData !== eData ||
          bus.oFillBusy !== eBusy || bus.oFillDone !== eDone || bus.oCpuStall !== expStall) begin
        failures++;
        $display("FAIL model_cycle t=%0t got we=%b addr=%0d data=%0d busy=%b done=%b stall=%b want we=%b addr=%0d data=%0d busy=%b done=%b stall=%b",
                 $time, bus.oWriteEnable, bus.oWriteAddress, bus.oWriteData, bus.oFillBusy,
                 bus.oFillDone, bus.oCpuStall, eWe, eAddr, eData, eBusy, eDone, expStall);
      end
      if (bus.oWriteEnable) begin
        wAddr.push_back(int'(bus.oWriteAddress));
        wData.push_back(int'(bus.oWriteData));
        lastWeCyc = cyc;
      end
      if (bus.oFillBusy) busyCount++;
      if (bus.oFillDone) begin
        doneCount++;
        lastDoneCyc = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, b0;
    bus.iCpuReq    = 1'b0;
    bus.iCpuAddr   = '0;
    bus.iCpuData   = '0;
    bus.iFillStart = 1'b0;
    bus.iFillX     = '0;
    bus.iFillY     = '0;
    bus.iFillW     = '0;
    bus.iFillH     = '0;
    bus.iFillColor = '0;

    // Reset state
    #1 Reset = 1'b0;
    #2;
    chk("rst_we", int'(bus.oWriteEnable), 0);
    chk("rst_addr", int'(bus.oWriteAddress), 0);
    chk("rst_data", int'(bus.oWriteData), 0);
    chk("rst_busy", int'(bus.oFillBusy), 0);
    chk("rst_done", int'(bus.oFillDone), 0);
    tick();
    Reset = 1'b1;
    tick();

    // 1: single CPU write
    bus.iCpuReq  = 1'b1;
    bus.iCpuAddr = 8'h25;
    bus.iCpuData = 3'b101;
    #1 chk("t1_stall", int'(bus.oCpuStall), 0);
    tick();
    chk("t1_we", int'(bus.oWriteEnable), 1);
    chk("t1_addr", int'(bus.oWriteAddress), 'h25);
    chk("t1_data", int'(bus.oWriteData), 5);
    bus.iCpuReq = 1'b0;
    tick();
    chk("t1_we_after", int'(bus.oWriteEnable), 0);
    tick();

    // 2: uncontended 3x2 fill
    base = wAddr.size();
    d0   = doneCount;
    b0   = busyCount;
    startFill(2, 3, 3, 2, 2);
    repeat (9) tick();
    chk("t2_nwrites", wAddr.size() - base, 6);
    chkEntry("t2_w0", base + 0, 50, 2);
    chkEntry("t2_w1", base + 1, 51, 2);
    chkEntry("t2_w2", base + 2, 52, 2);
    chkEntry("t2_w3", base + 3, 66, 2);
    chkEntry("t2_w4", base + 4, 67, 2);
    chkEntry("t2_w5", base + 5, 68, 2);
    chk("t2_done_pulses", doneCount - d0, 1);
    chk("t2_busy_cycles", busyCount - b0, 7);
    chk("t2_done_with_last_write", lastDoneCyc, lastWeCyc);

    // 3: clipped at bottom-right corner
    base = wAddr.size();
    d0   = doneCount;
    startFill(14, 11, 5, 4, 4);
    repeat (6) tick();
    chk("t3_nwrites", wAddr.size() - base, 2);
    chkEntry("t3_w0", base + 0, 190, 4);
    chkEntry("t3_w1", base + 1, 191, 4);
    chk("t3_done_pulses", doneCount - d0, 1);

    // 4: empty region
    base = wAddr.size();
    d0   = doneCount;
    b0   = busyCount;
    startFill(1, 1, 0, 3, 1);
    repeat (4) tick();
    chk("t4_nwrites", wAddr.size() - base, 0);
    chk("t4_busy_cycles", busyCount - b0, 1);
    chk("t4_done_pulses", doneCount - d0, 1);

    // 5: contended fill; CPU raises its request as the fill starts running
    base = wAddr.size();
    startFill(0, 0, 4, 1, 3);
    bus.iCpuReq  = 1'b1;
    bus.iCpuAddr = 8'h80;
    bus.iCpuData = 3'd7;
    for (int i = 0; i < 9; i++) begin
      #2 chk($sformatf("t5_stall_%0d", i), int'(bus.oCpuStall), i % 2);
      tick();
    end
    bus.iCpuReq = 1'b0;
    repeat (3) tick();
    chk("t5_nwrites", wAddr.size() - base, 9);
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) chkEntry($sformatf("t5_cpu_%0d", i), base + i, 128, 7);
      else            chkEntry($sformatf("t5_fill_%0d", i), base + i, i / 2, 3);
    end

    // 6: reset in the middle of a fill
    startFill(0, 0, 8, 1, 1);
    tick();
    tick();
    chk("t6_pre_we", int'(bus.oWriteEnable), 1);
    chk("t6_pre_addr", int'(bus.oWriteAddress), 1);
    #2 Reset = 1'b0;
    #1;
    chk("t6_rst_we", int'(bus.oWriteEnable), 0);
    chk("t6_rst_addr", int'(bus.oWriteAddress), 0);
    chk("t6_rst_data", int'(bus.oWriteData), 0);
    chk("t6_rst_busy", int'(bus.oFillBusy), 0);
    base = wAddr.size();
    d0   = doneCount;
    tick();
    tick();
    Reset = 1'b1;
    repeat (6) tick();
    chk("t6_no_writes", wAddr.size() - base, 0);
    chk("t6_no_done", doneCount - d0, 0);
    startFill(5, 2, 2, 1, 6);
    repeat (6) tick();
    chk("t6_new_nwrites", wAddr.size() - base, 2);
    chkEntry("t6_new_w0", base + 0, 37, 6);
    chkEntry("t6_new_w1", base + 1, 38, 6);
    chk("t6_new_done", doneCount - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
